// File: rtl/zero_regfile_pkg.sv
// Shared constants for the general-purpose register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zero_regfile_pkg;

    // Defaults shared with decode and writeback
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

    // Register 0 is the hardwired zero register
    localparam int ZERO_ADDR = 0;

    // Clear engine state encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/zero_regfile_clr_seq.sv
// Clear sequencer: walks every register address once, emitting a zero-write strobe.
// Latency: busy rises the cycle after rst/clr_req; lasts exactly 2**ADDR_W cycles.
// Backpressure: none; clr_req while busy is ignored, rst restarts the walk.
module zero_regfile_clr_seq
    import zero_regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;

    // State, pointer and busy flag; rst always forces a fresh walk from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // ptr is left alone here so it can never generate extra clears
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/zero_regfile.sv
// Register file with hardwired zero at register 0 and a built-in clear engine.
// Latency: writes land at the next edge; reads are combinational (optional forwarding).
// Backpressure: none; writes presented while busy are silently dropped.
module zero_regfile
    import zero_regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    localparam int                NREGS  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(ZERO_ADDR);

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_user_we;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WIDTH-1:0]  w_wr_dat;
    logic [WIDTH-1:0]  w_rdata1;
    logic [WIDTH-1:0]  w_rdata2;

    // Register 0 has no storage; it is produced as a constant on the read side
    logic [WIDTH-1:0] r_regs [1:NREGS-1];

    zero_regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // User writes only in IDLE, never to the zero register, never during reset
    assign w_user_we = we && !w_busy && !rst && (waddr != A_ZERO);

    // Clear engine owns the write port while busy and always writes zero
    assign w_wr_en   = w_busy ? w_clr_we   : w_user_we;
    assign w_wr_addr = w_busy ? w_clr_addr : waddr;
    assign w_wr_dat  = w_busy ? '0         : wdata;

    // Storage update; the clear pass through entry 0 simply matches nothing
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (w_wr_en && (w_wr_addr == ADDR_W'(i))) begin
                r_regs[i] <= w_wr_dat;
            end
        end
    end

    // Read ports: zero while busy or for register 0, then forwarding, then storage
    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        if (!w_busy) begin
            for (int i = 1; i < NREGS; i++) begin
                if (raddr1 == ADDR_W'(i)) begin
                    w_rdata1 = r_regs[i];
                end
                if (raddr2 == ADDR_W'(i)) begin
                    w_rdata2 = r_regs[i];
                end
            end
            if ((BYPASS != 0) && we && (waddr == raddr1) && (raddr1 != A_ZERO)) begin
                w_rdata1 = wdata;
            end
            if ((BYPASS != 0) && we && (waddr == raddr2) && (raddr2 != A_ZERO)) begin
                w_rdata2 = wdata;
            end
        end
    end

    assign busy   = w_busy;
    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;

endmodule

// File: tb/tb_zero_regfile.sv
// Directed bench for zero_regfile: default instance (forwarding on),
// a forwarding-off instance sharing its inputs, and a small 8x8 instance.
module tb_zero_regfile;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        nb_busy;
    logic [31:0] nb_rdata1;
    logic [31:0] nb_rdata2;

    logic        s_we;
    logic [2:0]  s_waddr;
    logic [7:0]  s_wdata;
    logic [2:0]  s_raddr1;
    logic [2:0]  s_raddr2;
    logic        s_busy;
    logic [7:0]  s_rdata1;
    logic [7:0]  s_rdata2;

    int n_vec;
    int n_err;

    zero_regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
    );

    zero_regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(nb_busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(nb_rdata1), .raddr2(raddr2), .rdata2(nb_rdata2)
    );

    zero_regfile #(.WIDTH(8), .ADDR_W(3), .BYPASS(1)) dut_s (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(s_busy),
        .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .rdata1(s_rdata1), .raddr2(s_raddr2), .rdata2(s_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        int s_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        raddr1 = 5'd9;
        raddr2 = 5'd0;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_busy got %b exp 1", busy);
        end
        n_vec++;
        if (rdata1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rd_while_busy got %h exp 00000000", rdata1);
        end
        cnt = 0;
        s_cnt = 0;
        while ((busy || s_busy) && cnt < 100) begin
            if (busy) cnt++;
            if (s_busy) s_cnt++;
            step();
        end
        n_vec++;
        if (cnt !== 32) begin
            n_err++;
            $display("FAIL reset_busy_len got %0d exp 32", cnt);
        end
        n_vec++;
        if (s_cnt !== 8) begin
            n_err++;
            $display("FAIL small_busy_len got %0d exp 8", s_cnt);
        end
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            n_vec++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                n_err++;
                $display("FAIL reset_zero a=%0d got %h/%h exp 0/0", a, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_write();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        waddr = 5'd0; wdata = 32'h12345678;
        step();
        we = 1'b0;
        raddr1 = 5'd5;
        raddr2 = 5'd0;
        #1;
        n_vec++;
        if (rdata1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_r5 got %h exp deadbeef", rdata1);
        end
        n_vec++;
        if (rdata2 !== 32'h0) begin
            n_err++;
            $display("FAIL write_r0 got %h exp 00000000", rdata2);
        end
        n_vec++;
        if (nb_rdata1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_r5_nb got %h exp deadbeef", nb_rdata1);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        #1;
        n_vec++;
        if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_fwd got %h/%h exp a5a5a5a5", rdata1, rdata2);
        end
        n_vec++;
        if (nb_rdata1 !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_off_old got %h exp 00000000", nb_rdata1);
        end
        step();
        we = 1'b0;
        #1;
        n_vec++;
        if (nb_rdata1 !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_off_new got %h exp a5a5a5a5", nb_rdata1);
        end
        // forwarding must never leak through the zero register
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        #1;
        n_vec++;
        if (rdata1 !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_r0 got %h exp 00000000", rdata1);
        end
        step();
        we = 1'b0;
    endtask

    task automatic test_clear_req();
        int cnt;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i) * 32'h01010101;
            step();
        end
        we = 1'b0;
        raddr2 = 5'd17;
        #1;
        n_vec++;
        if (rdata2 !== 32'h11111111) begin
            n_err++;
            $display("FAIL fill_r17 got %h exp 11111111", rdata2);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL clr_busy_rise got %b exp 1", busy);
        end
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            clr_req = (cnt == 10);
            we = (cnt == 12);
            waddr = 5'd3;
            wdata = 32'h33333333;
            if (cnt == 12) begin
                raddr1 = 5'd3;
                #1;
                n_vec++;
                if (rdata1 !== 32'h0) begin
                    n_err++;
                    $display("FAIL clr_rd_busy got %h exp 00000000", rdata1);
                end
            end
            step();
        end
        we = 1'b0;
        clr_req = 1'b0;
        n_vec++;
        if (cnt !== 32) begin
            n_err++;
            $display("FAIL clr_busy_len got %0d exp 32", cnt);
        end
        raddr1 = 5'd3;
        #1;
        n_vec++;
        if (rdata1 !== 32'h0) begin
            n_err++;
            $display("FAIL clr_drop_r3 got %h exp 00000000", rdata1);
        end
        for (int a = 1; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(a);
            #1;
            n_vec++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                n_err++;
                $display("FAIL clr_zero a=%0d got %h/%h exp 0/0", a, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_rst_mid_clear();
        int cnt;
        we = 1'b1; waddr = 5'd30; wdata = 32'hCAFEF00D;
        step();
        we = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (19) step();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy_c20 got %b exp 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
        n_vec++;
        if (cnt !== 32) begin
            n_err++;
            $display("FAIL mid_rst_busy_len got %0d exp 32", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            n_vec++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                n_err++;
                $display("FAIL mid_zero a=%0d got %h/%h exp 0/0", a, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_small();
        n_vec++;
        if (s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL small_idle got %b exp 0", s_busy);
        end
        s_we = 1'b1; s_waddr = 3'd7; s_wdata = 8'hFF;
        step();
        s_we = 1'b0;
        s_raddr1 = 3'd7;
        s_raddr2 = 3'd7;
        #1;
        n_vec++;
        if (s_rdata1 !== 8'hFF || s_rdata2 !== 8'hFF) begin
            n_err++;
            $display("FAIL small_r7 got %h/%h exp ff/ff", s_rdata1, s_rdata2);
        end
        s_raddr2 = 3'd0;
        #1;
        n_vec++;
        if (s_rdata2 !== 8'h0) begin
            n_err++;
            $display("FAIL small_r0 got %h exp 00", s_rdata2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; clr_req = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr1 = '0; s_raddr2 = '0;
        #1;
        test_reset();
        test_write();
        test_bypass();
        test_clear_req();
        test_rst_mid_clear();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zero_regfile.md
Name: zero_regfile

Overview:
- Parametrised general-purpose register file for the RISC datapath.
- Register 0 is hardwired to zero.
- Has a built-in sequential clear engine that walks every entry and writes zero after reset or on request.
- Sits between decode (read addresses) and writeback (write port). Supplies operands to the ALU and the zero constant for register 0.

Parameters:
- WIDTH, 32, data width of each register in bits
- ADDR_W, 5, address width; number of registers NREGS = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the stored value only

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- clr_req  input  1  single-cycle pulse requesting a full clear of the file
- busy  output  1  high while the clear engine runs; writes are blocked
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  WIDTH  read port 1 data (combinational)
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  WIDTH  read port 2 data (combinational)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, CLEAR. Internal pointer ptr is ADDR_W bits wide.
- Reset: on any rising edge with rst=1:
  - state <= CLEAR, ptr <= 0, regardless of current state.
  - busy reads 1 from the cycle after the reset edge.
  - rdata1/rdata2 read 0 throughout busy.
- CLEAR:
  - Each cycle writes 0 to reg[ptr] and increments ptr.
  - When ptr == NREGS-1, the final zero is written and state <= IDLE.
  - busy is high for exactly NREGS cycles, then falls.
- IDLE + clr_req=1: state <= CLEAR, ptr <= 0 on the next edge. busy rises the following cycle.
- clr_req while busy: ignored; no restart, no extension.
- rst and clr_req together: rst wins. The outcome is identical (CLEAR, ptr 0).
- Write, IDLE only: if we=1 and waddr != 0, reg[waddr] <= wdata at the rising edge.
  - Writes to address 0 are discarded.
  - Writes while busy are discarded silently; no stall or queueing.
- Read, combinational, per port:
  - If busy: 0.
  - Else if raddr == 0: 0 always.
  - Else if BYPASS=1 and we=1 and waddr == raddr: wdata.
  - Else: reg[raddr].
- Both ports may address the same register; each returns identical data.
- Register 0 is never stored. It is the constant zero at every read port in every mode.
- ptr is only meaningful in CLEAR. In IDLE its value is don't-care, and it must not wrap into extra clear cycles.
- No X may propagate: after the first completed clear, every register reads 0 until written.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE = 0 and ST_CLEAR = 1;
  - ZERO_ADDR = 0;
  - the default WIDTH and ADDR_W values shared with decode and writeback.
- One natural sub-module: zero_regfile_clr_seq. It contains the state register, ptr counter, busy flag and the clear write strobe/address.
- The top level muxes the clear-engine write (data 0) against the user write port and implements the read/bypass logic.

Test Plan:
- Reset for 1 cycle, then release:
  - busy=1 for exactly 32 cycles (defaults), then 0.
  - All 32 addresses read 0 on both ports.
- After the clear, write reg[5]=0xDEADBEEF and reg[0]=0x12345678, then read raddr1=5, raddr2=0:
  - rdata1=0xDEADBEEF, rdata2=0x00000000.
- BYPASS=1: we=1, waddr=7, wdata=0xA5A5A5A5 with raddr1=7 in the same cycle:
  - rdata1=0xA5A5A5A5 combinationally.
  - With BYPASS=0, rdata1 shows the old value (0) until after the edge.
- Pulse clr_req with regs 1..31 holding non-zero data:
  - busy rises the next cycle and lasts 32 cycles.
  - A write to reg[3] during busy is dropped; reg[3] reads 0 afterward.
  - A second clr_req at busy cycle 10 does not extend busy beyond 32 cycles.
- Assert rst at clear cycle 20:
  - ptr restarts; busy remains high for a further 32 cycles from the reset edge.
  - Afterwards all registers read 0.
- ADDR_W=3, WIDTH=8 instance:
  - busy lasts 8 cycles.
  - Write reg[7]=0xFF, then read both ports at address 7 → 0xFF on both.
